// File: rtl/knn_pkg.sv
// Shared types and constants for the k-NN result drain.
// Optional macro KNN_DRAIN_SKIP_EMPTY_EN adds the PEEK state used for empty-entry lookahead.
package knn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
`ifdef KNN_DRAIN_SKIP_EMPTY_EN
    PEEK,
`endif
    SEND,
    FINISH
  } drain_state_t;

  localparam int DEFAULT_K = 1;

  // Wide enough for any supported value width; users slice the low bits.
  localparam logic [255:0] EMPTY_VALUE = '1;

endpackage

// File: rtl/knn_result_drain_if.sv
// Output beat stream of the k-NN result drain (valid/ready with name, value and last marker).
interface knn_result_drain_if #(
  parameter int VAL_WIDTH = 32
);
  logic                 m_valid;
  logic                 m_ready;
  logic [31:0]          m_name;
  logic [VAL_WIDTH-1:0] m_value;
  logic                 m_last;

  modport master (
    output m_valid,
    output m_name,
    output m_value,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_name,
    input  m_value,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/knn_result_drain.sv
// Streams the K sorted entries of a result memory out as valid/ready beats.
// Define KNN_DRAIN_SKIP_EMPTY_EN to stop early at the first all-ones (empty) entry.
module knn_result_drain
  import knn_pkg::*;
#(
  parameter int VAL_WIDTH = 32,
  parameter int K         = DEFAULT_K
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic [7:0]           rd_addr,
  input  logic [31:0]          rd_name,
  input  logic [VAL_WIDTH-1:0] rd_value,
  knn_result_drain_if.master   m,
  output logic                 done
);

  localparam logic [7:0] LAST_IDX = 8'(K - 1);

  drain_state_t         state;
  logic [7:0]           idx;
  logic [7:0]           lookahead_addr;
  logic                 valid_reg;
  logic                 last_reg;
  logic                 done_reg;
  logic                 busy_reg;
  logic [7:0]           rd_addr_reg;
  logic [31:0]          name_reg;
  logic [VAL_WIDTH-1:0] value_reg;

`ifdef KNN_DRAIN_SKIP_EMPTY_EN
  logic value_empty;
  assign value_empty = (rd_value == EMPTY_VALUE[VAL_WIDTH-1:0]);
`endif

  // Next entry, clamped so the lookahead read never leaves the list.
  assign lookahead_addr = (idx == LAST_IDX) ? LAST_IDX : idx + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 8'd0;
      valid_reg   <= 1'b0;
      last_reg    <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      rd_addr_reg <= 8'd0;
      name_reg    <= '0;
      value_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            idx         <= 8'd0;
            rd_addr_reg <= 8'd0;
            busy_reg    <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          rd_addr_reg <= lookahead_addr;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          name_reg  <= rd_name;
          value_reg <= rd_value;
`ifdef KNN_DRAIN_SKIP_EMPTY_EN
          if (idx == 8'd0 && value_empty) begin
            done_reg <= 1'b1;
            state    <= FINISH;
          end else begin
            state <= PEEK;
          end
`else
          last_reg  <= (idx == LAST_IDX);
          valid_reg <= 1'b1;
          state     <= SEND;
`endif
        end
`ifdef KNN_DRAIN_SKIP_EMPTY_EN
        PEEK: begin
          // rd_value now holds the entry after idx; an empty one ends the list here.
          last_reg  <= (idx == LAST_IDX) | value_empty;
          valid_reg <= 1'b1;
          state     <= SEND;
        end
`endif
        SEND: begin
          if (m.m_ready) begin
            valid_reg <= 1'b0;
            if (last_reg) begin
              done_reg <= 1'b1;
              state    <= FINISH;
            end else begin
              idx         <= idx + 8'd1;
              rd_addr_reg <= idx + 8'd1;
              state       <= FETCH;
            end
          end
        end
        FINISH: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          last_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign rd_addr   = rd_addr_reg;
  assign m.m_valid = valid_reg;
  assign m.m_last  = last_reg;
  assign m.m_name  = name_reg;
  assign m.m_value = value_reg;

endmodule
